// File: rtl/instr_fetcher.sv
// Instruction-fetch stage: owns the fetch PC, issues one ICache request at a time,
// and queues {instr, pc, predicted-taken} for the decoder. A ROB flush redirects and squashes.
module instr_fetcher #(
    parameter int IQ_DEPTH = 16,
    parameter int IQ_AW    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        ic_req_valid,
    output logic [31:0] ic_req_pc,
    input  logic        ic_resp_valid,
    input  logic [31:0] ic_resp_instr,
    output logic        pred_instr_valid,
    output logic [31:0] pred_instr,
    output logic [31:0] pred_cur_pc,
    input  logic        pred_if_jump,
    input  logic [31:0] pred_pc,
    output logic        iq_out_valid,
    output logic [31:0] iq_out_instr,
    output logic [31:0] iq_out_pc,
    output logic        iq_out_pred_jump,
    input  logic        dec_ready,
    input  logic        rob_flush,
    input  logic [31:0] rob_redirect_pc
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

    localparam logic [IQ_AW:0]   DEPTH_C = (IQ_AW+1)'(IQ_DEPTH);
    localparam logic [IQ_AW:0]   CNT_ONE = (IQ_AW+1)'(1);
    localparam logic [IQ_AW-1:0] PTR_ONE = IQ_AW'(1);

    state_t           state;
    logic [31:0]      pc;
    logic [IQ_AW-1:0] head;
    logic [IQ_AW-1:0] tail;
    logic [IQ_AW:0]   count;

    logic [31:0] iq_instr [IQ_DEPTH];
    logic [31:0] iq_pc    [IQ_DEPTH];
    logic        iq_pj    [IQ_DEPTH];

    logic resp_in_wait;
    logic push;
    logic pop;

    assign resp_in_wait = (state == S_WAIT) && ic_resp_valid;
    assign push         = resp_in_wait && !rob_flush;
    assign pop          = iq_out_valid && dec_ready && !rob_flush;

    // Predictor sees the returning word and current PC with no register in between.
    assign pred_instr_valid = resp_in_wait;
    assign pred_instr       = ic_resp_instr;
    assign pred_cur_pc      = pc;
    assign ic_req_pc        = pc;

    assign iq_out_valid     = (count != '0);
    assign iq_out_instr     = iq_instr[head];
    assign iq_out_pc        = iq_pc[head];
    assign iq_out_pred_jump = iq_pj[head];

    // Control: FSM, PC and queue pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            pc           <= '0;
            ic_req_valid <= 1'b0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
        end else if (rdy) begin
            if (rob_flush) begin
                head         <= '0;
                tail         <= '0;
                count        <= '0;
                pc           <= rob_redirect_pc;
                ic_req_valid <= 1'b0;
                // An un-returned fetch must still be absorbed before re-issuing.
                if ((state == S_WAIT || state == S_DROP) && !ic_resp_valid)
                    state <= S_DROP;
                else
                    state <= S_IDLE;
            end else begin
                if (push)
                    tail <= tail + PTR_ONE;
                if (pop)
                    head <= head + PTR_ONE;
                if (push && !pop)
                    count <= count + CNT_ONE;
                else if (pop && !push)
                    count <= count - CNT_ONE;

                case (state)
                    S_IDLE: begin
                        if (count < DEPTH_C) begin
                            state        <= S_WAIT;
                            ic_req_valid <= 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (ic_resp_valid) begin
                            pc           <= pred_pc;
                            ic_req_valid <= 1'b0;
                            state        <= S_IDLE;
                        end
                    end
                    S_DROP: begin
                        ic_req_valid <= 1'b0;
                        if (ic_resp_valid)
                            state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Queue storage: data only, never reset.
    always_ff @(posedge clk) begin
        if (rdy && push) begin
            iq_instr[tail] <= ic_resp_instr;
            iq_pc[tail]    <= pc;
            iq_pj[tail]    <= pred_if_jump;
        end
    end

endmodule

// File: tb/tb_instr_fetcher.sv
// Scoreboard bench for instr_fetcher: directed ICache responses, a simple JAL predictor,
// and a monitor that checks every entry the decoder pops.
module tb_instr_fetcher;

    localparam logic [31:0] JAL_W = 32'h0100006F;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        ic_req_valid;
    logic [31:0] ic_req_pc;
    logic        ic_resp_valid;
    logic [31:0] ic_resp_instr;
    logic        pred_instr_valid;
    logic [31:0] pred_instr, pred_cur_pc;
    logic        pred_if_jump;
    logic [31:0] pred_pc;
    logic        iq_out_valid;
    logic [31:0] iq_out_instr, iq_out_pc;
    logic        iq_out_pred_jump;
    logic        dec_ready;
    logic        rob_flush;
    logic [31:0] rob_redirect_pc;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        pj;
    } ent_t;

    ent_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_pc;

    instr_fetcher #(.IQ_DEPTH(16), .IQ_AW(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .ic_req_valid(ic_req_valid), .ic_req_pc(ic_req_pc),
        .ic_resp_valid(ic_resp_valid), .ic_resp_instr(ic_resp_instr),
        .pred_instr_valid(pred_instr_valid), .pred_instr(pred_instr),
        .pred_cur_pc(pred_cur_pc), .pred_if_jump(pred_if_jump), .pred_pc(pred_pc),
        .iq_out_valid(iq_out_valid), .iq_out_instr(iq_out_instr),
        .iq_out_pc(iq_out_pc), .iq_out_pred_jump(iq_out_pred_jump),
        .dec_ready(dec_ready), .rob_flush(rob_flush), .rob_redirect_pc(rob_redirect_pc)
    );

    always #5 clk = ~clk;

    // Predictor device: the JAL word at 0x8 jumps +0x10, everything else falls through.
    assign pred_if_jump = pred_instr_valid && (pred_instr == JAL_W);
    assign pred_pc      = pred_cur_pc + (pred_if_jump ? 32'h10 : 32'h4);

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] instr_at(input logic [31:0] a);
        if (a == 32'h8) return JAL_W;
        return {a[19:0], 12'h013};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!ic_req_valid && n < 20) begin
            tick();
            n++;
        end
        check("req_wait", {127'd0, ic_req_valid}, 128'd1);
    endtask

    // ICache model: accept the pending request, answer after lat cycles.
    task automatic fetch(input int lat);
        logic [31:0] w;
        logic        tk;
        wait_req();
        check("req_pc", {96'd0, ic_req_pc}, {96'd0, exp_pc});
        repeat (lat) tick();
        w  = instr_at(exp_pc);
        tk = (w == JAL_W);
        ic_resp_valid = 1'b1;
        ic_resp_instr = w;
        sb.push_back('{instr: w, pc: exp_pc, pj: tk});
        exp_pc = exp_pc + (tk ? 32'h10 : 32'h4);
        tick();
        ic_resp_valid = 1'b0;
        ic_resp_instr = '0;
    endtask

    task automatic drain();
        int n = 0;
        dec_ready = 1'b1;
        while (iq_out_valid && n < 100) begin
            tick();
            n++;
        end
        check("drain_empty", {127'd0, iq_out_valid}, 128'd0);
        check("drain_sb_empty", 128'(sb.size()), 128'd0);
    endtask

    // Monitor: every pop the decoder makes must match the oldest expected entry.
    always @(negedge clk) begin
        ent_t e;
        if (!rst && rdy && !rob_flush && iq_out_valid && dec_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_pop", {95'd0, iq_out_instr, 1'b1}, 128'd0);
            end else begin
                e = sb.pop_front();
                check("iq_head", {63'd0, iq_out_instr, iq_out_pc, iq_out_pred_jump}, {63'd0, e});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] snap;
        int n;
        rst = 1'b1; rdy = 1'b1; ic_resp_valid = 1'b0; ic_resp_instr = '0;
        dec_ready = 1'b0; rob_flush = 1'b0; rob_redirect_pc = '0;
        exp_pc = '0;
        repeat (3) tick();
        check("rst_req_valid", {127'd0, ic_req_valid}, 128'd0);
        check("rst_iq_valid", {127'd0, iq_out_valid}, 128'd0);
        check("rst_pc", {96'd0, ic_req_pc}, 128'd0);
        rst = 1'b0;
        check("rel_req_low", {127'd0, ic_req_valid}, 128'd0);
        tick();
        check("rel_req_high", {127'd0, ic_req_valid}, 128'd1);

        // First fetch, latency 2, then the JAL at 0x8.
        fetch(2);
        check("first_head", {63'd0, iq_out_instr, iq_out_pc, iq_out_pred_jump},
              {63'd0, 32'h00000013, 32'h0, 1'b0});
        fetch(1);
        fetch(1);
        wait_req();
        check("jal_next_pc", {96'd0, ic_req_pc}, {96'd0, 32'h18});
        drain();

        // Fill the queue to 16 with the decoder stalled.
        dec_ready = 1'b0;
        repeat (16) fetch(1);
        for (int i = 0; i < 4; i++) begin
            check("full_no_req", {127'd0, ic_req_valid}, 128'd0);
            check("full_iq_valid", {127'd0, iq_out_valid}, 128'd1);
            tick();
        end
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        n = 0;
        while (!ic_req_valid && n < 2) begin
            tick();
            n++;
        end
        check("resume_after_pop", {127'd0, ic_req_valid}, 128'd1);
        dec_ready = 1'b1;
        repeat (24) fetch(1);
        drain();

        // Flush while waiting; the late response must be dropped.
        dec_ready = 1'b0;
        fetch(1);
        fetch(1);
        wait_req();
        rob_flush = 1'b1; rob_redirect_pc = 32'h100;
        sb.delete();
        exp_pc = 32'h100;
        tick();
        rob_flush = 1'b0;
        ic_resp_valid = 1'b1; ic_resp_instr = 32'hDEADBEEF;
        check("flush1_empty", {127'd0, iq_out_valid}, 128'd0);
        check("flush1_drop_req", {127'd0, ic_req_valid}, 128'd0);
        tick();
        ic_resp_valid = 1'b0; ic_resp_instr = '0;
        check("flush1_idle_req", {127'd0, ic_req_valid}, 128'd0);
        check("flush1_still_empty", {127'd0, iq_out_valid}, 128'd0);
        tick();
        check("flush1_reissue", {127'd0, ic_req_valid}, 128'd1);
        fetch(1);
        drain();

        // Flush coinciding with a response and a pop, three entries queued.
        dec_ready = 1'b0;
        repeat (3) fetch(1);
        wait_req();
        tick();
        ic_resp_valid = 1'b1; ic_resp_instr = instr_at(exp_pc);
        rob_flush = 1'b1; rob_redirect_pc = 32'h200; dec_ready = 1'b1;
        sb.delete();
        exp_pc = 32'h200;
        tick();
        ic_resp_valid = 1'b0; rob_flush = 1'b0; dec_ready = 1'b0;
        check("flush2_empty", {127'd0, iq_out_valid}, 128'd0);
        check("flush2_req_low", {127'd0, ic_req_valid}, 128'd0);
        tick();
        check("flush2_still_empty", {127'd0, iq_out_valid}, 128'd0);
        check("flush2_req_high", {127'd0, ic_req_valid}, 128'd1);
        check("flush2_req_pc", {96'd0, ic_req_pc}, {96'd0, 32'h200});
        fetch(1);
        fetch(1);

        // Freeze with rdy low while a request is outstanding.
        wait_req();
        snap = {30'd0, ic_req_valid, ic_req_pc, iq_out_valid, iq_out_instr, iq_out_pc, iq_out_pred_jump};
        rdy = 1'b0;
        dec_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rdy_hold",
                  {30'd0, ic_req_valid, ic_req_pc, iq_out_valid, iq_out_instr, iq_out_pc, iq_out_pred_jump},
                  snap);
        end
        rdy = 1'b1;
        fetch(1);
        fetch(2);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
